instr_fetch_unit: RTL

- Requester side of the instruction cache read port.
- Owns the program counter and issues one read per cycle to the cache: read enable plus PC, with the instruction returned combinationally in the same cycle.
- Buffers {pc, instruction} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and reloading the PC.

---
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Generic flop-based FIFO with synchronous flush and all storage cleared on reset.
// Latency: a push at edge N is visible at the head after edge N.
// Backpressure: pushes are ignored when full and pops when empty; flush overrides both.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// Instruction fetch: owns the PC, reads the cache every cycle, buffers {pc, instr} for decode.
// Latency: instruction fetched at edge N is presented to decode after edge N.
// Backpressure: fetch stalls when the buffer is full; redirect flushes and blocks fetch and delivery.
module instr_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     PC_INCR    = 4,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_fetch_en,
    output logic [XLEN-1:0] o_fetch_pc,
    input  logic [XLEN-1:0] i_fetch_instr,
    output logic            o_instr_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    input  logic            i_instr_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    logic [XLEN-1:0] pc_q;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;

    // Gating with i_rst_n keeps fetch quiet for the whole reset window, not just after the edge.
    assign o_fetch_en    = i_rst_n && !fifo_full && !i_redirect;
    assign o_fetch_pc    = pc_q;
    assign o_instr_valid = !fifo_empty && !i_redirect;
    assign pop           = o_instr_valid && i_instr_ready;

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = i_fetch_instr;
    assign o_instr        = head_entry.instr;
    assign o_instr_pc     = head_entry.pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q <= RESET_PC;
        end else if (i_redirect) begin
            pc_q <= i_redirect_pc;
        end else if (o_fetch_en) begin
            pc_q <= pc_q + XLEN'(PC_INCR);
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .core_clk (i_clk),
        .arst_n   (i_rst_n),
        .flush    (i_redirect),
        .push_vld (o_fetch_en),
        .push_dat (wr_entry),
        .pop_rdy  (pop),
        .head_dat (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
endmodule
